currency_accumulator: RTL

- Multi-slot successor to the single-input currency handler: N coin/note channels, each with its own 4-phase valid/ready handshake, feeding one running total.
- Adds price compare, vend with change, refund, and overflow rejection.
- Sits between the coin-slot front ends and the vending controller FSM.
- Channel requests may be asynchronous to clk and are synchronised internally.

---
 rtl/currency_accumulator_if.sv | 12 +
 rtl/currency_accumulator.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/currency_accumulator_if.sv
// Coin-channel bundle: per-channel value, 4-phase valid request and ready acknowledge.
interface currency_accumulator_if #(
   parameter int CURRENCY_WIDTH = 7,
   parameter int NUM_CHANNELS   = 4
);
   logic [NUM_CHANNELS*CURRENCY_WIDTH-1:0] currency_value;
   logic [NUM_CHANNELS-1:0]                currency_valid;
   logic [NUM_CHANNELS-1:0]                currency_ready;

   modport master (output currency_value, currency_valid, input currency_ready);
   modport slave  (input currency_value, currency_valid, output currency_ready);
endinterface

// File: rtl/currency_accumulator.sv
// Multi-channel coin accumulator with round-robin intake, vend with change, refund and overflow reject.
// Optional per-channel accepted-coin counters when COIN_COUNT_EN is defined.
module currency_accumulator #(
   parameter int CURRENCY_WIDTH = 7,
   parameter int NUM_CHANNELS   = 4,
   parameter int MAX_TOTAL      = 100,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   currency_accumulator_if.slave     bus,
   input  logic [CURRENCY_WIDTH-1:0] price,
   input  logic                      vend_req,
   input  logic                      refund_req,
   output logic [CURRENCY_WIDTH-1:0] total_currency,
   output logic [CURRENCY_WIDTH-1:0] change_value,
   output logic                      change_valid,
   output logic                      vend_done,
   output logic                      vend_fail,
   output logic                      reject,
   output logic                      busy
`ifdef COIN_COUNT_EN
   ,
   output logic [NUM_CHANNELS*8-1:0] coin_count
`endif
);
   localparam int W     = CURRENCY_WIDTH;
   localparam int PTR_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam logic [W:0] MAX_EXT = (W+1)'(MAX_TOTAL);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ADD  = 2'd1;
   localparam logic [1:0] ACK  = 2'd2;

   logic [1:0]              state;
   logic [NUM_CHANNELS-1:0] sync_q [SYNC_STAGES];
   logic [NUM_CHANNELS-1:0] vs;
   logic [NUM_CHANNELS-1:0] ready_q;
   logic [NUM_CHANNELS-1:0] pending;
   logic [PTR_W-1:0]        ptr;
   logic [PTR_W-1:0]        gidx;
   logic [PTR_W-1:0]        pick;
   logic                    found;
   logic [W-1:0]            gval;
   logic [W:0]              sum;
   logic                    sum_ok;
   int unsigned             cand;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= bus.currency_valid;
         for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign vs                 = sync_q[SYNC_STAGES-1];
   assign pending            = vs & ~ready_q;
   assign bus.currency_ready = ready_q;
   assign busy               = (state != IDLE);
   assign sum                = {1'b0, total_currency} + {1'b0, gval};
   assign sum_ok             = (sum <= MAX_EXT);

   // First pending channel scanning upward from the pointer, wrapping at NUM_CHANNELS.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = 0;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
         cand = int'(ptr) + i;
         if (cand >= NUM_CHANNELS) cand = cand - NUM_CHANNELS;
         if (!found && pending[cand]) begin
            found = 1'b1;
            pick  = PTR_W'(cand);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         ptr            <= '0;
         gidx           <= '0;
         gval           <= '0;
         ready_q        <= '0;
         total_currency <= '0;
         change_value   <= '0;
         change_valid   <= 1'b0;
         vend_done      <= 1'b0;
         vend_fail      <= 1'b0;
         reject         <= 1'b0;
      end else begin
         change_valid <= 1'b0;
         vend_done    <= 1'b0;
         vend_fail    <= 1'b0;
         reject       <= 1'b0;
         case (state)
            IDLE: begin
               if (refund_req) begin
                  change_value   <= total_currency;
                  change_valid   <= 1'b1;
                  total_currency <= '0;
               end else if (vend_req) begin
                  if (total_currency >= price) begin
                     change_value   <= total_currency - price;
                     change_valid   <= 1'b1;
                     vend_done      <= 1'b1;
                     total_currency <= '0;
                  end else begin
                     vend_fail <= 1'b1;
                  end
               end else if (found) begin
                  gidx  <= pick;
                  gval  <= bus.currency_value[pick*W +: W];
                  state <= ADD;
               end
            end
            ADD: begin
               if (sum_ok) total_currency <= sum[W-1:0];
               else        reject         <= 1'b1;
               ready_q[gidx] <= 1'b1;
               state         <= ACK;
            end
            ACK: begin
               if (!vs[gidx]) begin
                  ready_q[gidx] <= 1'b0;
                  ptr           <= (gidx == PTR_W'(NUM_CHANNELS-1)) ? '0 : gidx + 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef COIN_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         coin_count <= '0;
      end else if (state == ADD && sum_ok && coin_count[gidx*8 +: 8] != 8'hFF) begin
         coin_count[gidx*8 +: 8] <= coin_count[gidx*8 +: 8] + 8'd1;
      end
   end
`endif

endmodule
